// File: rtl/seq_div_unit_if.sv
// Handshake and operand/result bundle between the control unit (master) and the divider (slave).
interface seq_div_unit_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, div_by_zero, result
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, div_by_zero, result
    );
endinterface

// File: rtl/seq_div_unit.sv
// Multicycle restoring divider: one quotient bit per clock, signed/unsigned per operation,
// packed {remainder, quotient} result and divide-by-zero status.
module seq_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          clr_n,
    seq_div_unit_if.slave div_if
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned RES_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   dvd_q,    dvd_d;
    logic [WIDTH-1:0]   dvs_q,    dvs_d;
    logic [WIDTH-1:0]   quo_q,    quo_d;
    logic [WIDTH-1:0]   dmag_q,   dmag_d;
    logic [WIDTH-1:0]   prem_q,   prem_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               mode_q,   mode_d;
    logic               qneg_q,   qneg_d;
    logic               rneg_q,   rneg_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               dbz_q,    dbz_d;
    logic [RES_W-1:0]   result_q, result_d;

    logic               dvd_neg;
    logic               dvs_neg;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   trial;
    logic               trial_ok;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        dmag_d   = dmag_q;
        prem_d   = prem_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        result_d = result_q;

        dvd_neg  = mode_q & dvd_q[WIDTH-1];
        dvs_neg  = mode_q & dvs_q[WIDTH-1];
        shifted  = {prem_q, quo_q[WIDTH-1]};
        // Two guard bits: shifted can reach 2^(WIDTH+1)-1 with an unsigned MSB-set divisor
        trial    = {1'b0, shifted} - {2'b00, dmag_q};
        trial_ok = (trial[WIDTH+1:WIDTH] == 2'b00);
        quo_fix  = qneg_q ? (-quo_q)  : quo_q;
        rem_fix  = rneg_q ? (-prem_q) : prem_q;

        unique case (state_q)
            S_IDLE: begin
                if (div_if.start) begin
                    dvd_d   = div_if.dividend;
                    dvs_d   = div_if.divisor;
                    mode_d  = div_if.signed_mode;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (dvs_q == '0) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    dbz_d    = 1'b1;
                    result_d = {dvd_q, {WIDTH{1'b1}}};
                    state_d  = S_IDLE;
                end else begin
                    quo_d   = dvd_neg ? (-dvd_q) : dvd_q;
                    dmag_d  = dvs_neg ? (-dvs_q) : dvs_q;
                    qneg_d  = dvd_neg ^ dvs_neg;
                    rneg_d  = dvd_neg;
                    prem_d  = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                prem_d = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                quo_d  = {quo_q[WIDTH-2:0], trial_ok};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = {rem_fix, quo_fix};
                done_d   = 1'b1;
                busy_d   = 1'b0;
                dbz_d    = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            dmag_q   <= '0;
            prem_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            dmag_q   <= dmag_d;
            prem_q   <= prem_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
        end
    end

    assign div_if.busy        = busy_q;
    assign div_if.done        = done_q;
    assign div_if.div_by_zero = dbz_q;
    assign div_if.result      = result_q;
endmodule
